// File: rtl/alu_pipe_stage.sv
// Two-stage elastic ALU: S1 holds the operands, S2 holds the result.
// Each stage has a valid flag and forwards one entry per cycle when downstream can take it.
module alu_pipe_stage #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             co,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SLT = 3'd6, OP_PASS = 3'd7;

    logic             live_q;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0] a1_q, b1_q;
    logic [2:0]       op1_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [WIDTH-1:0] x2_q;
    logic             co2_q;

    logic             adv1, adv2, accept;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_x;
    logic             alu_co;

    assign adv2     = ~v2_q | out_ready;
    assign adv1     = ~v1_q | adv2;
    // live_q keeps the input closed until the first edge after reset release
    assign in_ready = adv1 & live_q;
    assign accept   = in_valid & in_ready;

    assign v1_d = adv1 ? accept : v1_q;
    assign v2_d = adv2 ? v1_q   : v2_q;

    assign sum  = {1'b0, a1_q} + {1'b0, b1_q};
    assign diff = {1'b0, a1_q} + {1'b0, ~b1_q} + (WIDTH+1)'(1);

    always_comb begin
        alu_x  = '0;
        alu_co = 1'b0;
        unique case (op1_q)
            OP_ADD:  {alu_co, alu_x} = sum;
            OP_SUB:  {alu_co, alu_x} = diff;
            OP_AND:  alu_x = a1_q & b1_q;
            OP_OR:   alu_x = a1_q | b1_q;
            OP_XOR:  alu_x = a1_q ^ b1_q;
            OP_NOT:  alu_x = ~a1_q;
            OP_SLT:  alu_x = {{(WIDTH-1){1'b0}}, $signed(a1_q) < $signed(b1_q)};
            OP_PASS: alu_x = b1_q;
            default: alu_x = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            op1_q  <= '0;
            tag1_q <= '0;
        end else begin
            live_q <= 1'b1;
            v1_q   <= v1_d;
            if (accept) begin
                a1_q   <= a;
                b1_q   <= b;
                op1_q  <= ctrl;
                tag1_q <= in_tag;
            end
        end
    end

    // Payload only moves when S1 actually holds an entry, so a held result stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            x2_q   <= '0;
            co2_q  <= 1'b0;
            tag2_q <= '0;
        end else begin
            v2_q <= v2_d;
            if (adv2 && v1_q) begin
                x2_q   <= alu_x;
                co2_q  <= alu_co;
                tag2_q <= tag1_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign x         = x2_q;
    assign co        = co2_q;
    assign out_tag   = tag2_q;
    assign busy      = v1_q | v2_q;
endmodule

// File: tb/tb_alu_pipe_stage.sv
// Bench for alu_pipe_stage: opcode-table model + in-order scoreboard, directed and random traffic.
module tb_alu_pipe_stage;
    localparam int W = 4;
    localparam int T = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, co, busy;
    logic [W-1:0] a, b, x;
    logic [2:0]   ctrl;
    logic [T-1:0] in_tag, out_tag;

    alu_pipe_stage #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ctrl(ctrl), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .co(co), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic         co;
        logic [T-1:0] tag;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0, bad = 0;
    int           cyc = 0, acc_cnt = 0, n_out = 0;
    int           rdy_pct = 100, vld_pct = 100, stall_cnt = 0;
    bit           check_lat = 0, bp_watch = 0;
    int           bp_base = 0;
    logic [W-1:0] res_x  [8];
    logic         res_co [8];
    int           res_seen [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Opcode table in plain integer arithmetic; returns {co, x}
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic [2:0] c);
        int ai = int'(av), bi = int'(bv);
        int sa = (ai >= 8) ? ai - 16 : ai;
        int sb = (bi >= 8) ? bi - 16 : bi;
        int r  = 0;
        bit f  = 0;
        case (c)
            3'd0: begin r = (ai + bi) % 16; f = (ai + bi) >= 16; end
            3'd1: begin r = (ai - bi + 16) % 16; f = ai >= bi; end
            3'd2: r = int'(av & bv);
            3'd3: r = int'(av | bv);
            3'd4: r = int'(av ^ bv);
            3'd5: r = 15 - ai;
            3'd6: r = (sa < sb) ? 1 : 0;
            default: r = bi;
        endcase
        return {f, W'(r)};
    endfunction

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    // Compare process: every meaningful output cycle is checked against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {29'd0, out_tag}, 32'hFFFF_FFFF);
                end else begin
                    chk("x",   {28'd0, x},       {28'd0, exp_q[0].x});
                    chk("co",  {31'd0, co},      {31'd0, exp_q[0].co});
                    chk("tag", {29'd0, out_tag}, {29'd0, exp_q[0].tag});
                    if (check_lat) chk("latency", cyc - exp_q[0].cyc, 2);
                    if (out_ready) begin
                        res_x[out_tag]  = x;
                        res_co[out_tag] = co;
                        res_seen[out_tag]++;
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                logic [W:0] m;
                m = model(a, b, ctrl);
                e.x = m[W-1:0]; e.co = m[W]; e.tag = in_tag; e.cyc = cyc;
                exp_q.push_back(e);
                acc_cnt++;
            end
        end
    end

    // Called aligned to posedge+1; returns aligned to posedge+1 after the accepting edge
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] c, input logic [T-1:0] t);
        bit acc = 0;
        int w   = 0;
        while (vld_pct < 100 && int'($urandom_range(99)) >= vld_pct) begin
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); ctrl = 3'($urandom); in_tag = T'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; a = av; b = bv; ctrl = c; in_tag = t;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc && bp_watch) begin
                chk("inready_fall_after_accepts", acc_cnt - bp_base, 2);
                bp_watch = 0;
            end
            @(posedge clk); #1;
            w++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int w = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_res();
        for (int i = 0; i < 8; i++) res_seen[i] = 0;
    endtask

    initial begin
        int o0;
        time t0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ctrl = '0; in_tag = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_x",         {28'd0, x},         0);
        chk("rst_busy",      {31'd0, busy},      0);
        chk("rst_in_ready",  {31'd0, in_ready},  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 1);

        // Pin the model with hand-computed values
        chk("model_add_ovf", {27'd0, model(4'hF, 4'h1, 3'd0)}, 5'b1_0000);
        chk("model_sub_brw", {27'd0, model(4'h3, 4'h5, 3'd1)}, 5'b0_1110);
        chk("model_slt",     {27'd0, model(4'h8, 4'h1, 3'd6)}, 5'b0_0001);
        chk("model_not",     {27'd0, model(4'h5, 4'h0, 3'd5)}, 5'b0_1010);

        // Directed opcode cases with fixed latency
        rdy_pct = 100; check_lat = 1; clear_res();
        @(posedge clk); #1;
        issue(4'h9, 4'h0, 3'd0, 3'd1);
        issue(4'h9, 4'h0, 3'd1, 3'd2);
        issue(4'hF, 4'h1, 3'd0, 3'd3);
        issue(4'h3, 4'h5, 3'd1, 3'd4);
        issue(4'h8, 4'h1, 3'd6, 3'd5);
        drain();
        chk("t1_x",  {28'd0, res_x[1]}, 4'h9); chk("t1_co", {31'd0, res_co[1]}, 0);
        chk("t2_x",  {28'd0, res_x[2]}, 4'h9); chk("t2_co", {31'd0, res_co[2]}, 1);
        chk("t3_x",  {28'd0, res_x[3]}, 4'h0); chk("t3_co", {31'd0, res_co[3]}, 1);
        chk("t4_x",  {28'd0, res_x[4]}, 4'hE); chk("t4_co", {31'd0, res_co[4]}, 0);
        chk("t5_x",  {28'd0, res_x[5]}, 4'h1); chk("t5_co", {31'd0, res_co[5]}, 0);
        for (int i = 1; i <= 5; i++) chk("seen_once", res_seen[i], 1);
        check_lat = 0;

        // Backpressure: consumer stalls 4 cycles while tags 0..5 stream in
        o0 = n_out;
        @(negedge clk) stall_cnt = 4;
        @(posedge clk); #1;
        bp_base = acc_cnt; bp_watch = 1; clear_res();
        for (int t = 0; t < 6; t++) issue(W'($urandom), W'($urandom), 3'($urandom), T'(t));
        drain();
        chk("bp_count", n_out - o0, 6);
        for (int t = 0; t < 6; t++) chk("bp_seen_once", res_seen[t], 1);
        chk("bp_fall_seen", {31'd0, bp_watch}, 0);

        // Full throughput: 16 ops in 16 cycles
        o0 = n_out; check_lat = 1;
        t0 = $time;
        for (int i = 0; i < 16; i++) issue(W'($urandom), W'($urandom), 3'($urandom), T'(i));
        chk("thru_cycles", int'(($time - t0) / 10), 16);
        drain();
        chk("thru_count", n_out - o0, 16);
        check_lat = 0;

        // Reset with two ops in flight
        rdy_pct = 0;
        @(posedge clk); #1;
        issue(4'h1, 4'h2, 3'd0, 3'd6);
        issue(4'h3, 4'h4, 3'd0, 3'd7);
        in_valid = 1'b0;
        chk("busy_before_rst", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_x",         {28'd0, x},         0);
        chk("midrst_tag",       {29'd0, out_tag},   0);
        chk("midrst_busy",      {31'd0, busy},      0);
        exp_q.delete();
        rdy_pct = 100;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", {30'd0, out_valid, busy}, 0);

        // Random traffic with random stalls
        o0 = n_out; rdy_pct = 60; vld_pct = 70;
        for (int i = 0; i < 1000; i++) issue(W'($urandom), W'($urandom), 3'($urandom), T'($urandom));
        vld_pct = 100; rdy_pct = 100;
        drain();
        chk("rand_count", n_out - o0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: sim did not finish");
        $fatal(1, "timeout");
    end
endmodule
